// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU control unit.
// Contents: opcodes, controller states, ALU controls and instruction field positions.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] ALU_AND    = 2'd0;
    localparam logic [1:0] ALU_OR     = 2'd1;
    localparam logic [1:0] ALU_ADDSUB = 2'd2;
    localparam logic [1:0] ALU_SLT    = 2'd3;

    localparam int OP_HI = 7;
    localparam int OP_LO = 4;
    localparam int RD_HI = 3;
    localparam int RD_LO = 2;
    localparam int RS_HI = 1;
    localparam int RS_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_READ   = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode decoder for the control unit.
// Produces instruction class flags and the ALU controls.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_alu,
    output logic       is_ld,
    output logic       is_st,
    output logic       is_halt,
    output logic       is_illegal,
    output logic [1:0] alu_op,
    output logic       alu_sub
);

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        is_alu     = 1'b0;
        is_ld      = 1'b0;
        is_st      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_AND;
        alu_sub    = 1'b0;
        case (opcode)
            OP_NOP:  ;
            OP_ADD:  begin is_alu = 1'b1; alu_op = ALU_ADDSUB; end
            OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_ADDSUB; alu_sub = 1'b1; end
            OP_AND:  is_alu = 1'b1;
            OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR; end
            OP_SLT:  begin is_alu = 1'b1; alu_op = ALU_SLT; end
            OP_LD:   is_ld = 1'b1;
            OP_ST:   is_st = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle controller for the 4-bit CPU datapath.
// Flow: fetch, decode, register read, execute, memory and writeback; holds IR and flags.
module cpu_ctrl_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] instr_in,
    input  logic       alu_carry,
    output logic       pc_en,
    output logic       rf_rw,
    output logic [1:0] rf_rs1,
    output logic [1:0] rf_rs2,
    output logic [1:0] rf_wa,
    output logic       wb_sel,
    output logic [1:0] alu_op,
    output logic       alu_sub,
    output logic       mem_rw,
    output logic       carry_flag,
    output logic       halted,
    output logic       illegal,
    output logic       busy
);

    if (DATA_W != 4 || ADDR_W != 4) begin : g_width_check
        $error("cpu_ctrl_fsm sequences a 4-bit datapath only");
    end

    state_t     state;
    logic [7:0] ir;
    logic       pc_en_q, rf_rw_q, mem_rw_q;

    logic       dec_alu, dec_ld, dec_st, dec_halt, dec_illegal, dec_nop;
    logic [1:0] dec_alu_op;
    logic       dec_alu_sub;
    logic [3:0] opcode;

    // In FETCH the opcode arriving on instr_in sets up the registered DECODE outputs.
    assign opcode = (state == S_FETCH) ? instr_in[OP_HI:OP_LO] : ir[OP_HI:OP_LO];

    cpu_decode u_decode (
        .opcode     (opcode),
        .is_alu     (dec_alu),
        .is_ld      (dec_ld),
        .is_st      (dec_st),
        .is_halt    (dec_halt),
        .is_illegal (dec_illegal),
        .alu_op     (dec_alu_op),
        .alu_sub    (dec_alu_sub)
    );

    assign dec_nop = ~(dec_alu | dec_ld | dec_st | dec_halt | dec_illegal);

    // Write strobes and pc_en are masked while rst is high so no write leaks out of the reset cycle.
    assign pc_en  = pc_en_q & ~rst;
    assign rf_rw  = rf_rw_q | rst;
    assign mem_rw = mem_rw_q | rst;

    // NOTE: all state and registered outputs use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ir         <= '0;
            pc_en_q    <= 1'b0;
            rf_rw_q    <= 1'b1;
            mem_rw_q   <= 1'b1;
            rf_rs1     <= '0;
            rf_rs2     <= '0;
            rf_wa      <= '0;
            wb_sel     <= 1'b0;
            alu_op     <= '0;
            alu_sub    <= 1'b0;
            carry_flag <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            pc_en_q  <= 1'b0;
            rf_rw_q  <= 1'b1;
            mem_rw_q <= 1'b1;
            rf_wa    <= '0;
            wb_sel   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    ir      <= instr_in;
                    pc_en_q <= dec_nop | dec_illegal;
                    state   <= S_DECODE;
                end
                S_DECODE: begin
                    if (dec_nop || dec_illegal) begin
                        illegal <= illegal | dec_illegal;
                        state   <= run ? S_FETCH : S_IDLE;
                        busy    <= run;
                    end else if (dec_halt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                        busy   <= 1'b0;
                    end else begin
                        rf_rs1 <= ir[RD_HI:RD_LO];
                        rf_rs2 <= ir[RS_HI:RS_LO];
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    // ALU controls stay stable until the next instruction so the result is held through writeback.
                    alu_op  <= dec_alu_op;
                    alu_sub <= dec_alu_sub;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (dec_alu && dec_alu_op == ALU_ADDSUB)
                        carry_flag <= alu_carry;
                    if (dec_ld || dec_st) begin
                        mem_rw_q <= ~dec_st;
                        pc_en_q  <= dec_st;
                        state    <= S_MEM;
                    end else begin
                        rf_rw_q <= 1'b0;
                        rf_wa   <= ir[RD_HI:RD_LO];
                        pc_en_q <= 1'b1;
                        state   <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dec_ld) begin
                        rf_rw_q <= 1'b0;
                        rf_wa   <= ir[RD_HI:RD_LO];
                        wb_sel  <= 1'b1;
                        pc_en_q <= 1'b1;
                        state   <= S_WB;
                    end else begin
                        state <= run ? S_FETCH : S_IDLE;
                        busy  <= run;
                    end
                end
                S_WB: begin
                    state <= run ? S_FETCH : S_IDLE;
                    busy  <= run;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: stimulus queues expected retire records, a monitor checks them.
// Inline checks cover reset, per-phase outputs, run-stop, HALT and mid-instruction reset.
module tb_cpu_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst, run, alu_carry;
    logic [7:0] instr_in;
    logic       pc_en, rf_rw, wb_sel, alu_sub, mem_rw, carry_flag, halted, illegal, busy;
    logic [1:0] rf_rs1, rf_rs2, rf_wa, alu_op;

    cpu_ctrl_fsm #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .instr_in   (instr_in),
        .alu_carry  (alu_carry),
        .pc_en      (pc_en),
        .rf_rw      (rf_rw),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .rf_wa      (rf_wa),
        .wb_sel     (wb_sel),
        .alu_op     (alu_op),
        .alu_sub    (alu_sub),
        .mem_rw     (mem_rw),
        .carry_flag (carry_flag),
        .halted     (halted),
        .illegal    (illegal),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] instr;
        logic       carry_in;
        int         lat;
        int         rf_wr;
        int         mem_wr;
        logic [1:0] rf_wa;
        logic       wb_sel;
        logic       carry;
        logic       ill;
        logic       chk_alu;
        logic [1:0] alu_op;
        logic       alu_sub;
    } exp_t;

    exp_t exp_q[$];
    exp_t vec[10];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] instr, input logic cin, input int lat,
                                input int rf_wr, input int mem_wr, input logic [1:0] wa,
                                input logic wbs, input logic cy, input logic ill,
                                input logic chk, input logic [1:0] op, input logic sub);
        exp_t e;
        e.instr = instr; e.carry_in = cin; e.lat = lat; e.rf_wr = rf_wr; e.mem_wr = mem_wr;
        e.rf_wa = wa; e.wb_sel = wbs; e.carry = cy; e.ill = ill;
        e.chk_alu = chk; e.alu_op = op; e.alu_sub = sub;
        return e;
    endfunction

    // Monitor: counts cycles and strobes per instruction, compares on every pc_en.
    int         mon_cnt = 0, mon_rfw = 0, mon_memw = 0;
    logic [1:0] cap_rs1, cap_rs2, cap_op;
    logic       cap_sub;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            mon_cnt = 0; mon_rfw = 0; mon_memw = 0;
        end else begin
            if (busy) mon_cnt++;
            if (!rf_rw) mon_rfw++;
            if (!mem_rw) mon_memw++;
            if (mon_cnt == 3) begin cap_rs1 = rf_rs1; cap_rs2 = rf_rs2; end
            if (mon_cnt == 4) begin cap_op = alu_op; cap_sub = alu_sub; end
            if (pc_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pc_en", {31'b0, pc_en}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check($sformatf("%02h latency", mon_e.instr), mon_cnt, mon_e.lat);
                    check($sformatf("%02h rf_write_pulses", mon_e.instr), mon_rfw, mon_e.rf_wr);
                    check($sformatf("%02h mem_write_pulses", mon_e.instr), mon_memw, mon_e.mem_wr);
                    check($sformatf("%02h carry_flag", mon_e.instr), carry_flag, mon_e.carry);
                    check($sformatf("%02h illegal", mon_e.instr), illegal, mon_e.ill);
                    if (mon_e.rf_wr == 1) begin
                        check($sformatf("%02h rf_wa", mon_e.instr), rf_wa, mon_e.rf_wa);
                        check($sformatf("%02h wb_sel", mon_e.instr), wb_sel, mon_e.wb_sel);
                    end
                    if (mon_e.lat > 2) begin
                        check($sformatf("%02h rf_rs1", mon_e.instr), cap_rs1, mon_e.instr[3:2]);
                        check($sformatf("%02h rf_rs2", mon_e.instr), cap_rs2, mon_e.instr[1:0]);
                    end
                    if (mon_e.chk_alu) begin
                        check($sformatf("%02h alu_op", mon_e.instr), cap_op, mon_e.alu_op);
                        check($sformatf("%02h alu_sub", mon_e.instr), cap_sub, mon_e.alu_sub);
                    end
                end
                mon_cnt = 0; mon_rfw = 0; mon_memw = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_retire();
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (pc_en === 1'b1) seen = 1'b1;
        end
        check("retire_seen", {31'b0, seen}, 32'd1);
    endtask

    task automatic do_instr(input exp_t e);
        instr_in  = e.instr;
        alu_carry = e.carry_in;
        exp_q.push_back(e);
        wait_retire();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // instr, cin, lat, rf_wr, mem_wr, rf_wa, wb_sel, carry, illegal, chk_alu, alu_op, alu_sub
        vec[0] = mk(8'h2B, 1'b1, 5, 1, 0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1);
        vec[1] = mk(8'h35, 1'b0, 5, 1, 0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        vec[2] = mk(8'h10, 1'b0, 5, 1, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        vec[3] = mk(8'h63, 1'b1, 6, 1, 0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        vec[4] = mk(8'h73, 1'b1, 5, 0, 1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        vec[5] = mk(8'h00, 1'b0, 2, 0, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        vec[6] = mk(8'h9F, 1'b0, 2, 0, 0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        vec[7] = mk(8'h16, 1'b1, 5, 1, 0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0);
        vec[8] = mk(8'h4E, 1'b0, 5, 1, 0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0);
        vec[9] = mk(8'h5D, 1'b0, 5, 1, 0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0);

        rst = 1'b1; run = 1'b0; instr_in = 8'h00; alu_carry = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst pc_en", pc_en, 0);
        check("rst rf_rw", rf_rw, 1);
        check("rst mem_rw", mem_rw, 1);
        check("rst carry_flag", carry_flag, 0);
        check("rst halted", halted, 0);
        check("rst illegal", illegal, 0);
        check("rst busy", busy, 0);
        check("rst alu_op", alu_op, 0);
        check("rst rf_wa", rf_wa, 0);
        check("rst wb_sel", wb_sel, 0);
        rst = 1'b0;
        tick();
        check("idle busy", busy, 0);

        // First ADD r1,r2 walked phase by phase.
        instr_in = 8'h16; alu_carry = 1'b0; run = 1'b1;
        exp_q.push_back(mk(8'h16, 1'b0, 5, 1, 0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0));
        tick(); check("fetch busy", busy, 1); check("fetch pc_en", pc_en, 0);
        tick(); check("decode pc_en", pc_en, 0);
        tick(); check("read rf_rs1", rf_rs1, 1); check("read rf_rs2", rf_rs2, 2); check("read rf_rw", rf_rw, 1);
        tick(); check("exec alu_op", alu_op, 2); check("exec alu_sub", alu_sub, 0); check("exec rf_rw", rf_rw, 1);
        tick(); check("wb rf_rw", rf_rw, 0); check("wb rf_wa", rf_wa, 1);
        check("wb wb_sel", wb_sel, 0); check("wb pc_en", pc_en, 1);
        tick(); check("after wb pc_en", pc_en, 0); check("after wb rf_rw", rf_rw, 1);

        for (int i = 0; i < 10; i++) do_instr(vec[i]);

        // run dropped during READ of an ADD: instruction completes, then IDLE.
        instr_in = 8'h16; alu_carry = 1'b0;
        exp_q.push_back(mk(8'h16, 1'b0, 5, 1, 0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0));
        tick(); tick(); tick();
        run = 1'b0;
        wait_retire();
        tick();
        check("stop busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stop pc_en", pc_en, 0);
            check("stop busy_hold", busy, 0);
        end

        // HALT ignores run and holds until reset.
        instr_in = 8'hF0; run = 1'b1;
        tick(); tick();
        check("halt decode halted", halted, 0);
        tick();
        check("halt halted", halted, 1);
        check("halt busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt hold halted", halted, 1);
            check("halt hold pc_en", pc_en, 0);
        end
        rst = 1'b1; run = 1'b0;
        tick();
        check("halt rst halted", halted, 0);
        check("halt rst illegal", illegal, 0);
        check("halt rst busy", busy, 0);
        rst = 1'b0;
        tick();

        // Reset during EXEC of ADD with carry pending.
        instr_in = 8'h16; alu_carry = 1'b1; run = 1'b1;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("exec rst rf_rw", rf_rw, 1);
        check("exec rst pc_en", pc_en, 0);
        run = 1'b0;
        tick();
        check("exec rst busy", busy, 0);
        check("exec rst carry", carry_flag, 0);
        check("exec rst rf_rw_next", rf_rw, 1);
        check("exec rst pc_en_next", pc_en, 0);
        rst = 1'b0;
        tick();
        check("exec rst idle rf_rw", rf_rw, 1);
        check("exec rst idle pc_en", pc_en, 0);

        // Reset during MEM of ST: the store strobe must not appear.
        instr_in = 8'h73; alu_carry = 1'b0; run = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("mem rst mem_rw", mem_rw, 1);
        check("mem rst pc_en", pc_en, 0);
        run = 1'b0;
        tick();
        check("mem rst busy", busy, 0);
        check("mem rst mem_rw_next", mem_rw, 1);
        check("mem rst illegal", illegal, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mem rst idle mem_rw", mem_rw, 1);
            check("mem rst idle pc_en", pc_en, 0);
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
